// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light display path: FSM states, channel ids,
// the per-channel held BCD record and the dark-anode constant.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_A = 2'd1,
        ST_CONV_B = 2'd2
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Captured conversion result; ovf doubles as "hundreds digit non-zero".
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
    } held_t;

    // A tens digit is a leading zero only when the hundreds digit is zero too.
    function automatic logic tens_is_lz(held_t h);
        return (h.tens == 4'd0) && !h.ovf;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Display scan timebase: a SCAN_DIV-cycle prescaler stepping a 2-bit digit index.
module scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre;

    // Prescaler wraps at SCAN_DIV-1; each wrap advances the lit digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= 2'd0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/bcd_display_sched.sv
// Round-robin sharing of one combinational HEX_BCD between two countdown
// channels, holding each channel's BCD result and scanning the four digits
// onto a common-anode display.
module bcd_display_sched
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] val_a,
    input  logic       req_a,
    output logic       ack_a,
    input  logic [7:0] val_b,
    input  logic       req_b,
    output logic       ack_b,
    output logic [7:0] bcd_hex,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hund,
    output logic       ovf_a,
    output logic       ovf_b,
    output logic [3:0] an,
    output logic [3:0] digit
);

    state_t state, state_nxt;
    ch_t    last_grant;
    held_t  held_a, held_b;
    logic   grant_a, grant_b, cap_a, cap_b;
    logic [1:0] idx;

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk (clk),
        .rst (rst),
        .idx (idx)
    );

    assign ovf_a = held_a.ovf;
    assign ovf_b = held_b.ovf;

    // Arbitration and next state: IDLE always sits between two conversions,
    // so each conversion takes exactly one grant cycle and one capture cycle.
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_a && (!req_b || last_grant == CH_B)) begin
                    grant_a   = 1'b1;
                    state_nxt = ST_CONV_A;
                end else if (req_b) begin
                    grant_b   = 1'b1;
                    state_nxt = ST_CONV_B;
                end
            end
            ST_CONV_A: begin
                cap_a     = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_CONV_B: begin
                cap_b     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, operand latch, result capture and ack pulses. Reset wins over a
    // capture in flight, so an interrupted conversion never acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= CH_B;
            bcd_hex    <= 8'd0;
            held_a     <= '0;
            held_b     <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_a <= cap_a;
            ack_b <= cap_b;
            if (grant_a)
                bcd_hex <= val_a;
            else if (grant_b)
                bcd_hex <= val_b;
            if (cap_a) begin
                held_a     <= '{tens: bcd_tens, ones: bcd_ones, ovf: (bcd_hund != 4'd0)};
                last_grant <= CH_A;
            end
            if (cap_b) begin
                held_b     <= '{tens: bcd_tens, ones: bcd_ones, ovf: (bcd_hund != 4'd0)};
                last_grant <= CH_B;
            end
        end
    end

    // Digit drive registered from the scan index; leading-zero tens slots go dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            an    <= AN_OFF;
            digit <= 4'd0;
        end else begin
            unique case (idx)
                2'd0: begin
                    an    <= 4'b1110;
                    digit <= held_b.ones;
                end
                2'd1: begin
                    if (LZ_BLANK && tens_is_lz(held_b)) begin
                        an    <= AN_OFF;
                        digit <= 4'd0;
                    end else begin
                        an    <= 4'b1101;
                        digit <= held_b.tens;
                    end
                end
                2'd2: begin
                    an    <= 4'b1011;
                    digit <= held_a.ones;
                end
                2'd3: begin
                    if (LZ_BLANK && tens_is_lz(held_a)) begin
                        an    <= AN_OFF;
                        digit <= 4'd0;
                    end else begin
                        an    <= 4'b0111;
                        digit <= held_a.tens;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_sched.sv
// Self-checking bench for bcd_display_sched with a behavioural HEX_BCD and a
// value-level reference model of arbitration, capture and display scanning.
module tb_bcd_display_sched;

    localparam int SD = 4;

    logic       clk, rst;
    logic [7:0] val_a, val_b, bcd_hex;
    logic       req_a, req_b, ack_a, ack_b, ovf_a, ovf_b;
    logic [3:0] bcd_ones, bcd_tens, bcd_hund, an, digit;

    int checks = 0;
    int errors = 0;

    bcd_display_sched #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .val_a(val_a), .req_a(req_a), .ack_a(ack_a),
        .val_b(val_b), .req_b(req_b), .ack_b(ack_b),
        .bcd_hex(bcd_hex), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .bcd_hund(bcd_hund),
        .ovf_a(ovf_a), .ovf_b(ovf_b), .an(an), .digit(digit)
    );

    // Behavioural shared HEX_BCD
    assign bcd_ones = 4'(bcd_hex % 8'd10);
    assign bcd_tens = 4'((bcd_hex / 8'd10) % 8'd10);
    assign bcd_hund = 4'(bcd_hex / 8'd100);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (binary values, plain arithmetic) -----
    int         m_cnt;        // edges since reset
    int         m_held[2];    // binary value last captured per channel (0=A,1=B)
    int         m_pend;       // channel being converted, -1 when none
    int         m_pend_val;
    int         m_last;
    logic [7:0] e_hex;
    logic       e_ack_a, e_ack_b;
    logic [3:0] e_an, e_dig;

    function automatic void disp(input int slot, input int va, input int vb,
                                 output logic [3:0] a_o, output logic [3:0] d_o);
        a_o = 4'b1111;
        d_o = 4'd0;
        case (slot)
            0: begin a_o = 4'b1110; d_o = 4'(vb % 10); end
            1: if (vb >= 10) begin a_o = 4'b1101; d_o = 4'((vb / 10) % 10); end
            2: begin a_o = 4'b1011; d_o = 4'(va % 10); end
            default: if (va >= 10) begin a_o = 4'b0111; d_o = 4'((va / 10) % 10); end
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_held[0] = 0; m_held[1] = 0; m_pend = -1; m_pend_val = 0;
            m_last = 1; e_hex = 8'd0; e_ack_a = 1'b0; e_ack_b = 1'b0;
            e_an = 4'b1111; e_dig = 4'd0;
        end else begin
            disp((m_cnt / SD) % 4, m_held[0], m_held[1], e_an, e_dig);
            m_cnt++;
            e_ack_a = 1'b0;
            e_ack_b = 1'b0;
            if (m_pend >= 0) begin
                m_held[m_pend] = m_pend_val;
                if (m_pend == 0) e_ack_a = 1'b1; else e_ack_b = 1'b1;
                m_last = m_pend;
                m_pend = -1;
            end else if (req_a || req_b) begin
                m_pend     = (req_a && req_b) ? 1 - m_last : (req_a ? 0 : 1);
                m_pend_val = (m_pend == 0) ? int'(val_a) : int'(val_b);
                e_hex      = 8'(m_pend_val);
            end
        end
    end

    // ---------------- checking helpers --------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("ack_a", int'(ack_a), int'(e_ack_a));
        chk("ack_b", int'(ack_b), int'(e_ack_b));
        chk("bcd_hex", int'(bcd_hex), int'(e_hex));
        chk("ovf_a", int'(ovf_a), (m_held[0] > 99) ? 1 : 0);
        chk("ovf_b", int'(ovf_b), (m_held[1] > 99) ? 1 : 0);
        chk("an", int'(an), int'(e_an));
        chk("digit", int'(digit), int'(e_dig));
        chk("ack_excl", int'(ack_a & ack_b), 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] val;
        logic       ch;       // 0=A 1=B
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; val_a = 8'd0; val_b = 8'd0;
        vecs[0] = '{8'd0,   1'b0, 1'b0};
        vecs[1] = '{8'd9,   1'b1, 1'b0};
        vecs[2] = '{8'd10,  1'b0, 1'b0};
        vecs[3] = '{8'd99,  1'b1, 1'b0};
        vecs[4] = '{8'd100, 1'b0, 1'b1};
        vecs[5] = '{8'd105, 1'b1, 1'b1};
        vecs[6] = '{8'd173, 1'b0, 1'b1};
        vecs[7] = '{8'd255, 1'b1, 1'b1};

        // Reset state
        do_reset();
        chk("rst_an", int'(an), 15);
        chk("rst_hex", int'(bcd_hex), 0);

        // 1: single A request of 173
        req_a = 1'b1; val_a = 8'd173;
        cyc();
        req_a = 1'b0;
        chk("t1_hex", int'(bcd_hex), 173);
        chk("t1_ack_early", int'(ack_a), 0);
        cyc();
        chk("t1_ack_a", int'(ack_a), 1);
        chk("t1_ovf_a", int'(ovf_a), 1);
        chk("t1_ack_b", int'(ack_b), 0);
        for (int i = 0; i < 3 * SD; i++) cyc();

        // 2: both held from reset -> A,B,A,B at 2-cycle spacing
        val_a = 8'd42; val_b = 8'd9; req_a = 1'b1; req_b = 1'b1;
        rst = 1'b1; cyc(); rst = 1'b0;
        begin
            int seq[$];
            for (int i = 0; i < 8; i++) begin
                cyc();
                if (ack_a) seq.push_back(0);
                if (ack_b) seq.push_back(1);
                if (i % 2 == 0) chk("t2_gap", int'(ack_a | ack_b), 0);
            end
            chk("t2_nacks", seq.size(), 4);
            for (int i = 0; i < seq.size(); i++) chk("t2_order", seq[i], i % 2);
        end
        req_a = 1'b0; req_b = 1'b0;

        // 3: full scan of 42 / 9 (model checks every cycle; spot-check blanking)
        for (int i = 0; i < 5 * SD; i++) begin
            cyc();
            if (an == 4'b1101) chk("t3_btens_blank", 1, 0);
        end

        // 4: B = 105 -> tens slot lit with 0
        val_b = 8'd105; req_b = 1'b1;
        cyc(); req_b = 1'b0; cyc();
        chk("t4_ovf_b", int'(ovf_b), 1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 6 * SD && !seen; i++) begin
                cyc();
                if (an == 4'b1101) begin
                    seen = 1'b1;
                    chk("t4_btens_digit", int'(digit), 0);
                end
            end
            chk("t4_btens_lit", int'(seen), 1);
        end

        // 5: operand latched at grant; req drop does not abort
        val_a = 8'd50; req_a = 1'b1;
        cyc();
        val_a = 8'd77; req_a = 1'b0;
        cyc();
        chk("t5_ack_a", int'(ack_a), 1);
        chk("t5_hex", int'(bcd_hex), 50);
        chk("t5_held", m_held[0], 50);

        // 6: reset during CONV_B
        val_b = 8'd61; req_b = 1'b1;
        cyc();
        req_b = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_ack_b", int'(ack_b), 0);
        chk("t6_ovf", int'(ovf_a | ovf_b), 0);
        chk("t6_an", int'(an), 15);
        chk("t6_hex", int'(bcd_hex), 0);
        val_b = 8'd33; req_b = 1'b1;
        cyc(); req_b = 1'b0; cyc();
        chk("t6_reconv", int'(ack_b), 1);

        // Table vectors
        foreach (vecs[k]) begin
            if (vecs[k].ch) begin val_b = vecs[k].val; req_b = 1'b1; end
            else            begin val_a = vecs[k].val; req_a = 1'b1; end
            cyc();
            req_a = 1'b0; req_b = 1'b0;
            chk("tbl_hex", int'(bcd_hex), int'(vecs[k].val));
            cyc();
            chk("tbl_ack", int'(vecs[k].ch ? ack_b : ack_a), 1);
            chk("tbl_ovf", int'(vecs[k].ch ? ovf_b : ovf_a), int'(vecs[k].exp_ovf));
            for (int i = 0; i < SD; i++) cyc();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 79) == 0);
            req_a = ($urandom_range(0, 2) != 0);
            req_b = ($urandom_range(0, 2) != 0);
            val_a = 8'($urandom_range(0, 255));
            val_b = 8'($urandom_range(0, 255));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_sched.md
Name: bcd_display_sched

Overview:
- Shares one combinational HEX_BCD converter between two 8-bit countdown requesters: channel A (north–south timer) and channel B (east–west timer).
- Holds the converted BCD result for each channel.
- Time-multiplexes the results onto a 4-digit common-anode seven-segment display. The segment decoder is downstream.
- Sits in the Traffic top level: between the phase timers, the single HEX_BCD instance and the segment decoder.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays lit; legal range 2..2^20.
- LZ_BLANK, 1, when 1 a tens digit is blanked if that channel's tens==0 and hundreds==0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- val_a  in  8  channel A binary value
- req_a  in  1  channel A conversion request, level
- ack_a  out  1  one-cycle pulse: channel A result captured
- val_b  in  8  channel B binary value
- req_b  in  1  channel B conversion request, level
- ack_b  out  1  one-cycle pulse: channel B result captured
- bcd_hex  out  8  registered operand to the shared HEX_BCD
- bcd_ones  in  4  HEX_BCD ones result
- bcd_tens  in  4  HEX_BCD tens result
- bcd_hund  in  4  HEX_BCD hundreds result
- ovf_a  out  1  channel A captured value >99
- ovf_b  out  1  channel B captured value >99
- an  out  4  digit anodes, active-low, one-hot or all-high
- digit  out  4  BCD code of the currently lit digit

Behaviour:
- One clock domain, clk. rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - state=IDLE, last_grant=B (so A wins first), bcd_hex=0.
  - Held BCD registers all 0; ovf_a=ovf_b=0; ack_a=ack_b=0.
  - an=4'b1111, digit=0, prescaler=0, scan index=0.
- FSM states: IDLE, CONV_A, CONV_B.
- IDLE, arbitration:
  - Only req_a: grant A.
  - Only req_b: grant B.
  - Both asserted: grant the channel opposite last_grant (round-robin).
  - On grant A: bcd_hex<=val_a, next state CONV_A. Grant B is symmetric.
  - No request: stay in IDLE, bcd_hex holds.
- CONV_x:
  - bcd_hex is stable for the whole cycle; HEX_BCD settles combinationally.
  - At the end of the cycle: capture ones/tens into channel x registers, set ovf_x<=(bcd_hund!=0), ack_x<=1 for one cycle, last_grant<=x, return to IDLE.
- Latency: request seen in IDLE at edge k → bcd_hex valid after edge k → capture and ack_x high after edge k+1.
  - Maximum two cycles per conversion; IDLE is always visited between conversions.
  - With both requests held continuously: ack pattern A,B,A,B with ack pulses every second cycle.
- val_x changing after grant is ignored for that conversion (value already latched).
- req_x dropping during CONV_x does not abort; capture and ack still occur.
- Never assert ack_a and ack_b in the same cycle.
- Scan path, independent of the FSM:
  - Prescaler counts 0..SCAN_DIV-1 and wraps; on wrap, scan index increments mod 4.
  - an and digit are registered from the scan index, so each digit is lit exactly SCAN_DIV cycles.
  - Digit mapping: idx0=B ones (an[0]), idx1=B tens (an[1]), idx2=A ones (an[2]), idx3=A tens (an[3]).
  - Blanking: when LZ_BLANK=1, a tens slot whose tens==0 and hundreds==0 drives an=4'b1111 and digit=0 for that slot.
  - Ones digits are never blanked.
- Hundreds digit is not displayed; overflow is reported only via ovf_x.
- Reset asserted mid-conversion: no ack is issued, all outputs return to reset values on the next edge, and the display goes dark until the next scan slot.

Decomposition:
- Shared package traffic_pkg holds:
  - state encodings ST_IDLE/ST_CONV_A/ST_CONV_B (2-bit);
  - channel ids CH_A=0, CH_B=1;
  - AN_OFF=4'b1111.
- One natural sub-module: scan_tick, holding the SCAN_DIV prescaler plus the 2-bit scan index.
- The FSM, arbiter and held registers stay in the parent.
- HEX_BCD is instantiated by the top level, not inside this block.

Test Plan:
1. Reset, then req_a=1 for one cycle with val_a=8'd173 → bcd_hex=173 the next cycle; ack_a one cycle later; A tens=7, ones=3, ovf_a=1; ack_b never asserts.
2. req_a and req_b held from reset, val_a=42, val_b=9 → ack order A,B,A,B at 2-cycle spacing; A holds 4/2, B holds 0/9; no simultaneous acks.
3. SCAN_DIV=4, values from scenario 2, LZ_BLANK=1 → an cycles 1110,1101,1011,0111 at 4 cycles each; digit=9 at idx0; idx1 shows an=1111 (B tens blanked); idx2=2; idx3=4.
4. val_b=8'd105 converted → B tens=0, ones=5, ovf_b=1; idx1 is lit with digit=0, because hundreds!=0 means no blanking.
5. Grant A with val_a=50, then change val_a to 77 during CONV_A and drop req_a → captured value 50 and ack_a still pulses.
6. Assert rst during CONV_B → no ack_b; next cycle all held registers and ovf flags are 0, an=1111, state IDLE; a following req_b converts normally.
